// File: rtl/nrzi_destuff_rx_if.sv
// Line-side sample inputs and byte-side outputs of the NRZI de-stuffing receiver.
interface nrzi_destuff_rx_if;
    logic       in_valid;
    logic       nrzi_in;
    logic       sync;
    logic [7:0] out_data;
    logic       out_valid;
    logic       stuff_err;

    // Sample source (line front end / testbench).
    modport master (
        output in_valid, nrzi_in, sync,
        input  out_data, out_valid, stuff_err
    );

    // Receiver.
    modport slave (
        input  in_valid, nrzi_in, sync,
        output out_data, out_valid, stuff_err
    );
endinterface

// File: rtl/nrzi_destuff_rx.sv
// NRZI decoder with bit de-stuffing and LSB-first byte assembly.
// Each accepted sample decodes to one bit: a line transition is a 1, and no
// transition is a 0. After STUFF_LEN consecutive 1s, the next bit must be a
// stuffed 0. That bit is dropped. A 1 in that position is a stuffing error.
module nrzi_destuff_rx #(
    parameter int STUFF_LEN = 6
) (
    input  logic              clk,
    input  logic              rst,
    nrzi_destuff_rx_if.slave  bus
);

    typedef enum logic {
        ST_DATA  = 1'b0,
        ST_STUFF = 1'b1
    } state_t;

    localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

    state_t     state_q,      state_d;
    logic       prev_level_q, prev_level_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [2:0] run_cnt_q,    run_cnt_d;
    logic [7:0] byte_q,       byte_d;
    logic [7:0] out_data_q,   out_data_d;
    logic       out_valid_q,  out_valid_d;
    logic       stuff_err_q,  stuff_err_d;

    logic       dec_bit;
    logic [7:0] byte_full;

    assign dec_bit = bus.nrzi_in ^ prev_level_q;

    // Next-state logic: sync beats in_valid, and a cleared in_valid freezes everything.
    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        bit_cnt_d    = bit_cnt_q;
        run_cnt_d    = run_cnt_q;
        byte_d       = byte_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        stuff_err_d  = 1'b0;
        byte_full    = byte_q;
        byte_full[bit_cnt_q] = dec_bit;

        if (bus.sync) begin
            // Realign the frame. The line level seen on this sample is ignored.
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
            run_cnt_d = 3'd0;
            byte_d    = 8'h00;
        end else if (bus.in_valid) begin
            prev_level_d = bus.nrzi_in;
            if (state_q == ST_STUFF) begin
                // The stuffed position never carries data. A 1 here breaks the frame.
                state_d = ST_DATA;
                if (dec_bit) begin
                    stuff_err_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    run_cnt_d   = 3'd0;
                    byte_d      = 8'h00;
                end
            end else begin
                byte_d    = byte_full;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    out_data_d  = byte_full;
                    out_valid_d = 1'b1;
                    byte_d      = 8'h00;
                end
                // Counting the run is independent of the byte boundary. A run can complete on bit 7.
                if (dec_bit) begin
                    if (run_cnt_q + 3'd1 == RUN_MAX) begin
                        run_cnt_d = 3'd0;
                        state_d   = ST_STUFF;
                    end else begin
                        run_cnt_d = run_cnt_q + 3'd1;
                    end
                end else begin
                    run_cnt_d = 3'd0;
                end
            end
        end
    end

    // State and registered outputs. Reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_DATA;
            prev_level_q <= 1'b0;
            bit_cnt_q    <= 3'd0;
            run_cnt_q    <= 3'd0;
            byte_q       <= 8'h00;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            bit_cnt_q    <= bit_cnt_d;
            run_cnt_q    <= run_cnt_d;
            byte_q       <= byte_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.stuff_err = stuff_err_q;

endmodule

// File: tb/tb_nrzi_destuff_rx.sv
// Directed testbench for nrzi_destuff_rx. A queue-based reference model
// predicts the outputs on every cycle. Literal checks pin the expected bytes and pulse counts.
module tb_nrzi_destuff_rx;
    localparam int SL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    nrzi_destuff_rx_if bus();

    nrzi_destuff_rx #(.STUFF_LEN(SL)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_vld   = 0;
    int n_err   = 0;
    bit chk_en  = 1'b0;

    // Reference model state: the decoded bit stream, reduced to a queue of pending data bits.
    bit       m_prev;
    int       m_ones;
    bit       m_expect_stuff;
    bit       m_q[$];
    bit [7:0] exp_data = 8'h00;
    bit       exp_valid = 1'b0;
    bit       exp_err = 1'b0;

    // Encoder state on the testbench side.
    logic tb_lvl  = 1'b0;
    int   enc_ones = 0;

    function automatic void model_step(input bit v, input bit l, input bit s, input bit r);
        bit d;
        bit [7:0] b;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (r) begin
            m_prev = 0; m_ones = 0; m_expect_stuff = 0; m_q.delete(); exp_data = 8'h00;
        end else if (s) begin
            m_ones = 0; m_expect_stuff = 0; m_q.delete();
        end else if (v) begin
            d = l ^ m_prev;
            m_prev = l;
            if (m_expect_stuff) begin
                m_expect_stuff = 0;
                if (d) begin
                    exp_err = 1'b1;
                    m_q.delete();
                    m_ones = 0;
                end
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) b[i] = m_q[i];
                    exp_data  = b;
                    exp_valid = 1'b1;
                    m_q.delete();
                end
                if (d) begin
                    m_ones++;
                    if (m_ones == SL) begin
                        m_ones = 0;
                        m_expect_stuff = 1;
                    end
                end else begin
                    m_ones = 0;
                end
            end
        end
    endfunction

    // Every-cycle comparison against the model, one clock after each sampling edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_tests++;
            if (bus.out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL out_valid t=%0t got %b want %b", $time, bus.out_valid, exp_valid);
            end
            n_tests++;
            if (bus.stuff_err !== exp_err) begin
                n_fail++;
                $display("FAIL stuff_err t=%0t got %b want %b", $time, bus.stuff_err, exp_err);
            end
            n_tests++;
            if (bus.out_data !== exp_data) begin
                n_fail++;
                $display("FAIL out_data t=%0t got %h want %h", $time, bus.out_data, exp_data);
            end
            n_tests++;
            if (bus.out_valid === 1'b1 && bus.stuff_err === 1'b1) begin
                n_fail++;
                $display("FAIL exclusive t=%0t got both high want at most one", $time);
            end
            if (bus.out_valid === 1'b1) n_vld++;
            if (bus.stuff_err === 1'b1) n_err++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic l, input logic s, input logic r);
        bus.in_valid = v;
        bus.nrzi_in  = l;
        bus.sync     = s;
        rst          = r;
        model_step(v, l, s, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        tb_lvl   = 1'b0;
        enc_ones = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gaps(input int n);
        for (int g = 0; g < n; g++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    // NRZI-encode bits [first..last] of b, inserting stuffed 0s, with `gap` idle cycles after each sample.
    task automatic send_bits(input logic [7:0] b, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            if (b[i]) tb_lvl = ~tb_lvl;
            cyc(1'b1, tb_lvl, 1'b0, 1'b0);
            gaps(gap);
            if (b[i]) begin
                enc_ones++;
                if (enc_ones == SL) begin
                    enc_ones = 0;
                    cyc(1'b1, tb_lvl, 1'b0, 1'b0);
                    gaps(gap);
                end
            end else begin
                enc_ones = 0;
            end
        end
    endtask

    task automatic send_levels(input logic [15:0] lv, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, lv[i], 1'b0, 1'b0);
    endtask

    int v0, e0;

    initial begin
        bus.in_valid = 1'b0;
        bus.nrzi_in  = 1'b0;
        bus.sync     = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset state.
        do_reset();
        check_lit("reset_data", int'(bus.out_data), 8'h00);

        // Raw levels 1,1,0,0,0,1,1,0 decode to 0xA5.
        v0 = n_vld; e0 = n_err;
        send_levels(16'b0000_0000_0110_0011, 8);
        check_lit("a5_pulses", n_vld - v0, 1);
        check_lit("a5_errs", n_err - e0, 0);
        check_lit("a5_data", int'(bus.out_data), 8'hA5);
        check_lit("a5_model", int'(exp_data), 8'hA5);

        // 0xFF with a stuffed 0 after the sixth 1. The byte appears only after the 9th sample.
        do_reset();
        v0 = n_vld;
        send_levels(16'b0000_0000_1001_0101, 8);
        check_lit("ff_early", n_vld - v0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("ff_pulses", n_vld - v0, 1);
        check_lit("ff_data", int'(bus.out_data), 8'hFF);

        // Seven 1s: stuffing violation on the 7th sample, then recovery.
        do_reset();
        v0 = n_vld; e0 = n_err;
        send_levels(16'b0000_0000_0101_0101, 7);
        check_lit("err_pulses", n_err - e0, 1);
        check_lit("err_no_byte", n_vld - v0, 0);
        tb_lvl = 1'b1; enc_ones = 0;
        send_bits(8'h3C, 0, 7, 0);
        check_lit("err_recover_pulses", n_vld - v0, 1);
        check_lit("err_recover_data", int'(bus.out_data), 8'h3C);

        // 0xA5 with three idle cycles between samples.
        do_reset();
        v0 = n_vld;
        send_bits(8'hA5, 0, 7, 3);
        check_lit("gap_pulses", n_vld - v0, 1);
        check_lit("gap_data", int'(bus.out_data), 8'hA5);

        // Four stale bits, then sync with a toggled level that must be ignored, then 0x3C.
        do_reset();
        v0 = n_vld;
        send_bits(8'hFF, 0, 3, 0);
        cyc(1'b1, ~tb_lvl, 1'b1, 1'b0);
        enc_ones = 0;
        send_bits(8'h3C, 0, 7, 0);
        check_lit("sync_pulses", n_vld - v0, 1);
        check_lit("sync_data", int'(bus.out_data), 8'h3C);

        // Five bits, a mid-byte reset, then 0xA5. out_data stays 0 until the byte completes.
        do_reset();
        send_bits(8'h5A, 0, 7, 0);
        v0 = n_vld;
        send_bits(8'h3C, 0, 4, 0);
        cyc(1'b1, ~tb_lvl, 1'b0, 1'b1);
        tb_lvl = 1'b0; enc_ones = 0;
        check_lit("rst_mid_data", int'(bus.out_data), 8'h00);
        send_bits(8'hA5, 0, 6, 0);
        check_lit("rst_pre_data", int'(bus.out_data), 8'h00);
        send_bits(8'hA5, 7, 7, 0);
        check_lit("rst_pulses", n_vld - v0, 1);
        check_lit("rst_data", int'(bus.out_data), 8'hA5);

        // A run of six 1s that ends on bit 7. The stuffed 0 falls into the next byte.
        do_reset();
        v0 = n_vld; e0 = n_err;
        send_bits(8'hFC, 0, 7, 0);
        check_lit("b7run_data", int'(bus.out_data), 8'hFC);
        send_bits(8'h81, 0, 7, 1);
        check_lit("b7run_pulses", n_vld - v0, 2);
        check_lit("b7run_errs", n_err - e0, 0);
        check_lit("b7run_data2", int'(bus.out_data), 8'h81);

        gaps(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
